// File: rtl/arm_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// arm_multicycle_ctrl_if
//   Bundle between the multicycle ARM datapath and its control unit.
//   Instruction fields and ALU flags flow datapath -> controller.
//   Enables, mux selects and the debug state code flow controller -> datapath.
//   slave  : controller side (arm_multicycle_ctrl)
//   master : datapath side (or a testbench standing in for it)
// ----------------------------------------------------------------------------
interface arm_multicycle_ctrl_if;
    // instruction fields / ALU status
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    // control outputs
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] State;

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
    );

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// arm_multicycle_ctrl
//   Main control unit of the multicycle ARM core (data-processing, LDR/STR, B).
//   A Moore FSM sequences each instruction; architectural writes are gated by
//   the condition result latched when leaving DECODE; the NZCV register lives
//   here and is updated when leaving EXECR/EXECI.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low; forces FETCH, FLAGS_RESET, enables 0
//   bus    - arm_multicycle_ctrl_if.slave: Cond/Op/Funct/Rd/ALUFlags in,
//            all enables, mux selects, ImmSrc, RegSrc, ALUControl, State out
// ----------------------------------------------------------------------------
module arm_multicycle_ctrl #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    arm_multicycle_ctrl_if.slave bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    // ------------------------------------------------------------------
    // State register (plus flags and latched condition)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            flags_q   <= FLAGS_RESET;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;   // undefined op: NOP
                endcase
            end
            S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;          // incl. illegal codes 10-15
        endcase
    end

    // ------------------------------------------------------------------
    // Condition check against the registered flags
    // ------------------------------------------------------------------
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (bus.Cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Gating is frozen at DECODE so flag updates by this same instruction
    // cannot change whether its own writeback happens.
    assign cond_ex_d = (state_q == S_DECODE) ? cond_pass : cond_ex_q;

    // ------------------------------------------------------------------
    // ALU command decode
    // ------------------------------------------------------------------
    logic [1:0] alu_ctrl_dec;
    logic       cmd_legal, is_cmp, is_arith;

    always_comb begin
        alu_ctrl_dec = 2'b00;
        cmd_legal    = 1'b1;
        is_cmp       = 1'b0;
        is_arith     = 1'b0;
        case (bus.Funct[4:1])
            4'b0100: begin alu_ctrl_dec = 2'b00; is_arith = 1'b1; end
            4'b0010: begin alu_ctrl_dec = 2'b01; is_arith = 1'b1; end
            4'b1010: begin alu_ctrl_dec = 2'b01; is_arith = 1'b1; is_cmp = 1'b1; end
            4'b0000: alu_ctrl_dec = 2'b10;
            4'b1100: alu_ctrl_dec = 2'b11;
            default: cmd_legal = 1'b0;
        endcase
    end

    logic in_exec;
    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

    // CMP sets flags regardless of the S bit; logical ops leave C/V alone.
    always_comb begin
        flags_d = flags_q;
        if (in_exec && cond_ex_q && cmd_legal && (bus.Funct[0] || is_cmp)) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (is_arith)
                flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    logic       pc_write, mem_write, reg_write, ir_write;
    logic       adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b;
    logic       rd_is_pc, alu_wb_wr;

    assign rd_is_pc  = (bus.Rd == 4'd15);
    assign alu_wb_wr = cond_ex_q & cmd_legal & ~is_cmp;

    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        result_src = 2'b00;
        alu_src_b  = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src   = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex_q;
                pc_write   = cond_ex_q & rd_is_pc;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
            end
            S_EXECR: alu_src_b = 2'b00;
            S_EXECI: alu_src_b = 2'b01;
            S_ALUWB: begin
                reg_write = alu_wb_wr;
                pc_write  = alu_wb_wr & rd_is_pc;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex_q;
            end
            default: ;
        endcase
        // Enables are killed combinationally so nothing commits while reset
        // is held, even though the state already reads FETCH.
        if (!reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.ALUControl = in_exec ? alu_ctrl_dec : 2'b00;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
module tb_arm_multicycle_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // reference model state: architectural flags only
    logic [3:0] m_flags;

    arm_multicycle_ctrl_if bus_if();

    arm_multicycle_ctrl #(.FLAGS_RESET(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Each condition pair shares a base predicate; the odd code inverts it.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cc, v, base;
        {n, z, cc, v} = fl;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,State}
    function automatic logic [15:0] mk(input logic [3:0] st, input logic pcw, input logic mw,
                                       input logic rw, input logic irw, input logic adr,
                                       input logic [1:0] res, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] alu);
        return {pcw, mw, rw, irw, adr, res, sa, sb, alu, st};
    endfunction

    function automatic logic [19:0] observe();
        return {bus_if.ImmSrc, bus_if.RegSrc, bus_if.PCWrite, bus_if.MemWrite,
                bus_if.RegWrite, bus_if.IRWrite, bus_if.AdrSrc, bus_if.ResultSrc,
                bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUControl, bus_if.State};
    endfunction

    // Run one full instruction starting in FETCH; compare every cycle.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] af, input string nm);
        logic [15:0] exp_q[$];
        logic [3:0]  code;
        logic        ce, legal, cmp, arith, wr;
        logic [1:0]  alu;
        logic [3:0]  side;
        logic [19:0] got;

        ce    = cond_ok(c, m_flags);
        code  = f[4:1];
        legal = 1'b1; cmp = 1'b0; arith = 1'b0; alu = 2'b00;
        if (code == 4'b0100) begin alu = 2'b00; arith = 1'b1; end
        else if (code == 4'b0010) begin alu = 2'b01; arith = 1'b1; end
        else if (code == 4'b1010) begin alu = 2'b01; arith = 1'b1; cmp = 1'b1; end
        else if (code == 4'b0000) alu = 2'b10;
        else if (code == 4'b1100) alu = 2'b11;
        else begin legal = 1'b0; alu = 2'b00; end

        exp_q.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00));
        exp_q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00));
        if (o == 2'b01) begin
            exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00));
            if (f[0]) begin
                exp_q.push_back(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00));
                exp_q.push_back(mk(4'd4, ce && rd == 15, 0, ce, 0, 0, 2'b01, 0, 2'b00, 2'b00));
            end else begin
                exp_q.push_back(mk(4'd5, 0, ce, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00));
            end
        end else if (o == 2'b00) begin
            wr = ce && legal && !cmp;
            exp_q.push_back(mk(f[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 2'b00, 0,
                               f[5] ? 2'b01 : 2'b00, alu));
            exp_q.push_back(mk(4'd8, wr && rd == 15, 0, wr, 0, 0, 2'b00, 0, 2'b00, 2'b00));
        end else if (o == 2'b10) begin
            exp_q.push_back(mk(4'd9, ce, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00));
        end

        side = {o, (o == 2'b01), (o == 2'b10)};
        bus_if.Cond = c; bus_if.Op = o; bus_if.Funct = f; bus_if.Rd = rd; bus_if.ALUFlags = af;

        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== {side, exp_q[i]}) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", nm, i, got, {side, exp_q[i]});
            end
            @(posedge clk);
            #1;
        end

        // flag effect of the instruction
        if (o == 2'b00 && ce && legal && (f[0] || cmp)) begin
            m_flags[3:2] = af[3:2];
            if (arith) m_flags[1:0] = af[1:0];
        end
    endtask

    task automatic check_rst(input string nm);
        checks++;
        if (bus_if.State !== 4'd0 ||
            {bus_if.PCWrite, bus_if.MemWrite, bus_if.RegWrite, bus_if.IRWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: got state %0d enables %b expected state 0 enables 0000", nm,
                     bus_if.State,
                     {bus_if.PCWrite, bus_if.MemWrite, bus_if.RegWrite, bus_if.IRWrite});
        end
    endtask

    task automatic check_release(input string nm);
        checks++;
        if (bus_if.State !== 4'd0 || bus_if.IRWrite !== 1'b1 || bus_if.PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL %s: got state %0d IRWrite %b PCWrite %b expected 0 1 1", nm,
                     bus_if.State, bus_if.IRWrite, bus_if.PCWrite);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_if.Cond = 4'he; bus_if.Op = 2'b00; bus_if.Funct = 6'b001000;
        bus_if.Rd = 4'd1; bus_if.ALUFlags = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rst("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_release("reset_release");
        m_flags = 4'b0000;
    endtask

    task automatic test_ldr();
        run_instr(4'he, 2'b01, 6'b011001, 4'd3, 4'h0, "ldr");
        run_instr(4'he, 2'b01, 6'b011001, 4'd15, 4'h0, "ldr_pc");
    endtask

    task automatic test_subs_addeq();
        run_instr(4'he, 2'b00, 6'b000101, 4'd2, 4'b0110, "subs");
        run_instr(4'h0, 2'b00, 6'b001000, 4'd4, 4'b0000, "addeq");
        run_instr(4'h1, 2'b00, 6'b001000, 4'd4, 4'b0000, "addne");
    endtask

    task automatic test_cmp_bne();
        run_instr(4'he, 2'b00, 6'b010101, 4'd0, 4'b0100, "cmp");
        run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, "bne");
        run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, "beq");
    endtask

    task automatic test_str_orr();
        run_instr(4'h1, 2'b01, 6'b011000, 4'd5, 4'h0, "strne");
        run_instr(4'he, 2'b01, 6'b011000, 4'd5, 4'h0, "str");
        run_instr(4'he, 2'b00, 6'b111000, 4'd15, 4'h0, "orr_imm_pc");
    endtask

    task automatic test_undef_nv();
        run_instr(4'he, 2'b11, 6'b011001, 4'd15, 4'hf, "undef_op");
        run_instr(4'hf, 2'b00, 6'b001001, 4'd6, 4'b1111, "add_nv");
        run_instr(4'he, 2'b00, 6'b011111, 4'd6, 4'b1111, "illegal_cmd");
        run_instr(4'h0, 2'b00, 6'b001000, 4'd6, 4'h0, "addeq_after_nv");
    endtask

    task automatic test_back_to_back();
        logic [3:0] cmds[5];
        logic [3:0] c, rd, af, cmd;
        logic [1:0] o;
        logic [5:0] f;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b1010;
        cmds[3] = 4'b0000; cmds[4] = 4'b1100;
        for (int n = 0; n < 250; n++) begin
            c   = 4'($urandom_range(0, 15));
            o   = 2'($urandom_range(0, 3));
            cmd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                               : cmds[$urandom_range(0, 4)];
            f   = {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))};
            rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            af  = 4'($urandom_range(0, 15));
            run_instr(c, o, f, rd, af, "random");
        end
    endtask

    task automatic test_reset_mid();
        // make Z=1 so a reset that clears flags is visible through EQ
        run_instr(4'he, 2'b00, 6'b000101, 4'd2, 4'b0100, "subs_z");
        bus_if.Cond = 4'he; bus_if.Op = 2'b01; bus_if.Funct = 6'b011001;
        bus_if.Rd = 4'd7; bus_if.ALUFlags = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_if.State !== 4'd3) begin
            errors++;
            $display("FAIL mid_memrd: got state %0d expected 3", bus_if.State);
        end
        reset = 1'b0;
        #1;
        check_rst("reset_mid_assert");
        @(posedge clk);
        #1;
        check_rst("reset_mid_hold");
        reset = 1'b1;
        #1;
        check_release("reset_mid_release");
        m_flags = 4'b0000;
        run_instr(4'h0, 2'b00, 6'b001000, 4'd8, 4'h0, "addeq_after_reset");
        run_instr(4'h1, 2'b00, 6'b001000, 4'd8, 4'h0, "addne_after_reset");
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_flags = 4'b0000;
        reset   = 1'b0;
        bus_if.Cond = 4'h0; bus_if.Op = 2'b00; bus_if.Funct = 6'h00;
        bus_if.Rd = 4'h0; bus_if.ALUFlags = 4'h0;
        test_reset();
        test_ldr();
        test_subs_addeq();
        test_cmp_bne();
        test_str_orr();
        test_undef_nv();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
